// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Instruction-memory bus between the fetch stage (master) and
//                the instruction cache/memory (slave). Same-cycle response:
//                IMEM_DATA is valid for IMEM_ADDR whenever IMEM_HIT is high.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_REQ;
  logic        IMEM_HIT;
  logic [31:0] IMEM_DATA;

  modport master (
    output IMEM_ADDR,
    output IMEM_REQ,
    input  IMEM_HIT,
    input  IMEM_DATA
  );

  modport slave (
    input  IMEM_ADDR,
    input  IMEM_REQ,
    output IMEM_HIT,
    output IMEM_DATA
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage of the 32-bit RISC pipeline. Owns the
//                PC, issues one word fetch per cycle, registers the fetched
//                word into the IF/ID outputs, waits out cache misses, honours
//                downstream stalls and branch redirects, and counts misses.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  wire               clk,
  input  wire               rst_n,
  input  wire               STALL,
  input  wire               BRANCH_TAKEN,
  input  wire  [31:0]       BRANCH_TARGET,
  fetch_stage_if.master     imem,
  output logic [31:0]       INSTRUCTION,
  output logic [31:0]       PC_OUT,
  output logic              HIT_OUT,
  output logic [CNT_W-1:0]  MISS_COUNT
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_MISS = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [31:0]      c_pc_step = 32'd4;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [31:0]      r_pc_out;
  logic             r_hit_out;
  logic [CNT_W-1:0] r_miss_count;

  // Redirect target is always word aligned; the low two bits are discarded.
  logic [31:0] w_branch_pc;
  logic        w_unused_tgt_lsbs;

  assign w_branch_pc       = {BRANCH_TARGET[31:2], 2'b00};
  assign w_unused_tgt_lsbs = ^BRANCH_TARGET[1:0];

  // The fetch address is the PC itself; the request is live in both states
  // (a stalled or missing fetch keeps presenting the same address).
  assign imem.IMEM_ADDR = r_pc;
  assign imem.IMEM_REQ  = rst_n && ((r_state == ST_RUN) || (r_state == ST_MISS));

  assign INSTRUCTION = r_instr;
  assign PC_OUT      = r_pc_out;
  assign HIT_OUT     = r_hit_out;
  assign MISS_COUNT  = r_miss_count;

  // Fetch FSM and IF/ID register: branch beats stall, stall beats fetch result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_instr      <= NOP_INSTR;
      r_pc_out     <= 32'h0000_0000;
      r_hit_out    <= 1'b0;
      r_miss_count <= '0;
    end else if (BRANCH_TAKEN) begin
      // Redirect abandons any outstanding miss; the target is fetched next cycle.
      r_state   <= ST_RUN;
      r_pc      <= w_branch_pc;
      r_instr   <= NOP_INSTR;
      r_hit_out <= 1'b0;
    end else if (STALL) begin
      // Everything holds; a hit arriving now is dropped and must be re-presented.
      r_state <= r_state;
    end else if (imem.IMEM_HIT) begin
      r_state   <= ST_RUN;
      r_instr   <= imem.IMEM_DATA;
      r_pc_out  <= r_pc;
      r_hit_out <= 1'b1;
      r_pc      <= r_pc + c_pc_step;
    end else begin
      // Bubble while the memory is not ready; only the RUN->MISS edge counts.
      r_instr   <= NOP_INSTR;
      r_hit_out <= 1'b0;
      if (r_state == ST_RUN) begin
        r_state <= ST_MISS;
        if (r_miss_count != c_cnt_max) begin
          r_miss_count <= r_miss_count + c_cnt_one;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed self-checking bench for fetch_stage. Two instances:
//                default parameters, and RESET_PC=FFFF_FFFC with CNT_W=2 for
//                the wrap and saturation cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] c_key = 32'hA5A5_0000;

  typedef struct {
    logic        hit;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        hit_en;

  logic [31:0] instr0, pc_out0, instr1, pc_out1;
  logic        hit_out0, hit_out1;
  logic [15:0] miss_count0;
  logic [1:0]  miss_count1;

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];

  fetch_stage_if bus0 ();
  fetch_stage_if bus1 ();

  // Same-cycle memory model: data is a fixed function of the address.
  assign bus0.IMEM_HIT  = hit_en;
  assign bus0.IMEM_DATA = hit_en ? (bus0.IMEM_ADDR ^ c_key) : 32'hDEAD_BEEF;
  assign bus1.IMEM_HIT  = hit_en;
  assign bus1.IMEM_DATA = hit_en ? (bus1.IMEM_ADDR ^ c_key) : 32'hDEAD_BEEF;

  fetch_stage u_dut0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .STALL         (stall),
    .BRANCH_TAKEN  (branch_taken),
    .BRANCH_TARGET (branch_target),
    .imem          (bus0.master),
    .INSTRUCTION   (instr0),
    .PC_OUT        (pc_out0),
    .HIT_OUT       (hit_out0),
    .MISS_COUNT    (miss_count0)
  );

  fetch_stage #(
    .RESET_PC (32'hFFFF_FFFC),
    .CNT_W    (2)
  ) u_dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .STALL         (stall),
    .BRANCH_TAKEN  (branch_taken),
    .BRANCH_TARGET (branch_target),
    .imem          (bus1.master),
    .INSTRUCTION   (instr1),
    .PC_OUT        (pc_out1),
    .HIT_OUT       (hit_out1),
    .MISS_COUNT    (miss_count1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of stimulus, record its expected IF/ID result, then
  // compare after the edge against the selected instance.
  task automatic step(input logic sel, input logic st, input logic br,
                      input logic [31:0] tgt, input logic hit,
                      input logic e_hit, input logic [31:0] e_pc,
                      input logic [31:0] e_addr);
    exp_t e;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    hit_en        = hit;
    e.hit   = e_hit;
    e.pc    = e_pc;
    e.instr = e_hit ? (e_pc ^ c_key) : 32'h0000_0000;
    e.addr  = e_addr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("hit_out", {31'd0, sel ? hit_out1 : hit_out0}, {31'd0, e.hit});
    chk("instruction", sel ? instr1 : instr0, e.instr);
    chk("imem_addr", sel ? bus1.IMEM_ADDR : bus0.IMEM_ADDR, e.addr);
    chk("imem_req", {31'd0, sel ? bus1.IMEM_REQ : bus0.IMEM_REQ}, 32'd1);
    if (e.hit) chk("pc_out", sel ? pc_out1 : pc_out0, e.pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; hit_en = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_hit_out", {31'd0, hit_out0}, 32'd0);
    chk("rst_instr", instr0, 32'h0);
    chk("rst_pc_out", pc_out0, 32'h0);
    chk("rst_miss_count", {16'd0, miss_count0}, 32'd0);
    chk("rst_imem_req", {31'd0, bus0.IMEM_REQ}, 32'd0);
    chk("rst_imem_addr", bus0.IMEM_ADDR, 32'h0);
    chk("rst_imem_addr_hi", bus1.IMEM_ADDR, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    // 1. Streaming hits from address 0
    for (int a = 0; a < 16; a += 4)
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, a, a + 4);

    // 2. Three-cycle miss at 0x10
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h10);
    chk("miss_count_miss1", {16'd0, miss_count0}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'h14);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h14, 32'h18);
    chk("miss_count_after_miss", {16'd0, miss_count0}, 32'd1);

    // 3. Two-cycle stall with memory hitting: everything frozen
    repeat (2) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h14, 32'h18);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h18, 32'h1C);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1C, 32'h20);

    // 4a. Branch alone to 0x103 (aligned to 0x100)
    step(1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b0, 32'h0, 32'h100);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h104);
    // 4b. Branch together with stall
    step(1'b0, 1'b1, 1'b1, 32'h0000_0103, 1'b1, 1'b0, 32'h0, 32'h100);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h104);
    chk("miss_count_branch", {16'd0, miss_count0}, 32'd1);

    // 5. Branch during a miss abandons it
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h104);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h104);
    chk("miss_count_miss2", {16'd0, miss_count0}, 32'd2);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0, 32'h40);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h44);
    chk("miss_count_abandon", {16'd0, miss_count0}, 32'd2);
    // Back in RUN: a fresh miss is counted
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h44);
    chk("miss_count_run_again", {16'd0, miss_count0}, 32'd3);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h44, 32'h48);

    // 6a. Asynchronous reset in the middle of a miss
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h48);
    chk("miss_count_pre_reset", {16'd0, miss_count0}, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hit_out", {31'd0, hit_out0}, 32'd0);
    chk("arst_instr", instr0, 32'h0);
    chk("arst_pc_out", pc_out0, 32'h0);
    chk("arst_miss_count", {16'd0, miss_count0}, 32'd0);
    chk("arst_imem_req", {31'd0, bus0.IMEM_REQ}, 32'd0);
    chk("arst_imem_addr", bus0.IMEM_ADDR, 32'h0);
    chk("arst_imem_addr_hi", bus1.IMEM_ADDR, 32'hFFFF_FFFC);
    chk("arst_miss_count_hi", {30'd0, miss_count1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 6b. PC wrap from FFFF_FFFC to 0
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h4);

    // 6c. Five misses saturate a 2-bit counter at 3
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'(4 + 4 * i));
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'(4 + 4 * i), 32'(8 + 4 * i));
      if (i == 2) chk("sat_count_3rd", {30'd0, miss_count1}, 32'd3);
    end
    chk("sat_count_final", {30'd0, miss_count1}, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
